// File: rtl/video_pkg.sv
// Shared video definitions: frame geometry, colour constants and frame buffer state.
// Used by the frame buffer, the scan-out stage and the CPU bridge.
package video_pkg;

    localparam int FRAME_WIDTH  = 160;
    localparam int FRAME_HEIGHT = 144;
    localparam int PIXEL_BITS   = 3;
    localparam int FB_ADDR_BITS = 15;
    localparam int FB_WORDS     = FRAME_WIDTH * FRAME_HEIGHT;

    localparam logic [PIXEL_BITS-1:0] BLACK   = 3'b000;
    localparam logic [PIXEL_BITS-1:0] BLUE    = 3'b001;
    localparam logic [PIXEL_BITS-1:0] GREEN   = 3'b010;
    localparam logic [PIXEL_BITS-1:0] CYAN    = 3'b011;
    localparam logic [PIXEL_BITS-1:0] RED     = 3'b100;
    localparam logic [PIXEL_BITS-1:0] MAGENTA = 3'b101;
    localparam logic [PIXEL_BITS-1:0] YELLOW  = 3'b110;
    localparam logic [PIXEL_BITS-1:0] WHITE   = 3'b111;

    typedef enum logic {
        FB_IDLE,
        FB_CLEAR
    } fb_state_t;

    // Linear pixel address y*FRAME_WIDTH + x, only meaningful for in-range x/y.
    function automatic logic [FB_ADDR_BITS-1:0] fb_addr(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return FB_ADDR_BITS'(int'(y) * FRAME_WIDTH + int'(x));
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// CPU pixel write port: valid/ready handshake carrying one pixel per beat.
// The CPU bridge is the master, the frame buffer the slave.
interface frame_buffer_if;
    import video_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [7:0]            x;
    logic [7:0]            y;
    logic [PIXEL_BITS-1:0] color;

    modport master (
        output valid,
        output x,
        output y,
        output color,
        input  ready
    );

    modport slave (
        input  valid,
        input  x,
        input  y,
        input  color,
        output ready
    );

endinterface

// File: rtl/fb_dpram.sv
// Simple dual-port pixel RAM: two banks of one frame each, addressed as {bank, addr}.
// One synchronous write port and one registered read port, suited to block RAM.
module fb_dpram
    import video_pkg::*;
#(
    parameter int DW    = PIXEL_BITS,
    parameter int AW    = FB_ADDR_BITS + 1,
    parameter int WORDS = FB_WORDS
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2][WORDS];

    // Write port and registered read port share the pixel clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[AW-1]][waddr[AW-2:0]] <= wdata;
        end
        rdata <= mem[raddr[AW-1]][raddr[AW-2:0]];
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 160x144 frame store feeding scan-out; banks swap on vsync fall.
// Define FB_CLEAR_EN to sweep the new back bank with CLEAR_COLOR after every swap.
module frame_buffer
    import video_pkg::*;
#(
    parameter logic [PIXEL_BITS-1:0] CLEAR_COLOR = WHITE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic [7:0]            row,
    input  logic [7:0]            column,
    output logic [PIXEL_BITS-1:0] pixel_data,
    frame_buffer_if.slave         wr,
    input  logic                  swap_req,
    output logic                  swap_pending,
    output logic                  swap_done,
    output logic                  front_bank
);

    localparam int AW = FB_ADDR_BITS + 1;

    logic vsync_q, vsync_d;
    logic front_q, front_d;
    logic pend_q, pend_d;
    logic done_q, done_d;
    logic rd_ok_q, rd_ok_d;

    logic                    vsync_fall;
    logic                    swap_go;
    logic                    fsm_idle;
    logic                    clr_busy;
    logic [FB_ADDR_BITS-1:0] clr_addr;
    logic                    wr_fire;
    logic                    wr_in;

    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [PIXEL_BITS-1:0] ram_wdata;
    logic [AW-1:0]         ram_raddr;
    logic [PIXEL_BITS-1:0] ram_rdata;

    assign vsync_fall = vsync_q & ~vsync;
    assign swap_go    = vsync_fall & (pend_q | swap_req) & fsm_idle;

`ifdef FB_CLEAR_EN
    localparam logic [FB_ADDR_BITS-1:0] CLR_LAST = FB_ADDR_BITS'(FB_WORDS - 1);

    fb_state_t               state_q, state_d;
    logic [FB_ADDR_BITS-1:0] clr_q, clr_d;

    // Clear sweep state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FB_IDLE;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // A swap starts a sweep of the new back bank; the last address returns to idle.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            FB_IDLE: begin
                if (swap_go) begin
                    state_d = FB_CLEAR;
                    clr_d   = '0;
                end
            end
            FB_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = FB_IDLE;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
        endcase
    end

    assign fsm_idle = (state_q == FB_IDLE);
    assign clr_busy = (state_q == FB_CLEAR);
    assign clr_addr = clr_q;
`else
    assign fsm_idle = 1'b1;
    assign clr_busy = 1'b0;
    assign clr_addr = '0;
`endif

    assign wr.ready = fsm_idle;
    assign wr_fire  = wr.valid & wr.ready;
    assign wr_in    = (wr.x < 8'(FRAME_WIDTH)) && (wr.y < 8'(FRAME_HEIGHT));

    // Next state of swap tracking and read qualification.
    always_comb begin
        vsync_d = vsync;
        front_d = front_q ^ swap_go;
        done_d  = swap_go;
        pend_d  = pend_q;
        if (swap_go) begin
            pend_d = 1'b0;
        end else if (swap_req) begin
            pend_d = 1'b1;
        end
        rd_ok_d = (row < 8'(FRAME_HEIGHT)) && (column < 8'(FRAME_WIDTH));
    end

    // Swap, vsync edge detect and read-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b1;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Only the back bank is ever written: by the sweep or by in-range CPU pixels.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {~front_q, fb_addr(wr.x, wr.y)};
        ram_wdata = wr.color;
        if (clr_busy) begin
            ram_we    = 1'b1;
            ram_waddr = {~front_q, clr_addr};
            ram_wdata = CLEAR_COLOR;
        end else if (wr_fire && wr_in) begin
            ram_we = 1'b1;
        end
    end

    assign ram_raddr = {front_q, fb_addr(column, row)};

    fb_dpram #(
        .DW    (PIXEL_BITS),
        .AW    (AW),
        .WORDS (FB_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign pixel_data   = rd_ok_q ? ram_rdata : '0;
    assign swap_pending = pend_q;
    assign swap_done    = done_q;
    assign front_bank   = front_q;

endmodule
